// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the fetch (ibus) and load/store (dbus) requesters.
// Data wins ties unless fetch has been passed over STARVE_LIMIT times; one transaction in flight.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic [63:0] i_req_addr,
  output logic        i_resp_addr_ok,
  output logic        i_resp_data_ok,
  output logic [31:0] i_resp_data,
  input  logic        d_req_valid,
  input  logic        d_req_write,
  input  logic [2:0]  d_req_size,
  input  logic [63:0] d_req_addr,
  input  logic [7:0]  d_req_strobe,
  input  logic [63:0] d_req_wdata,
  output logic        d_resp_addr_ok,
  output logic        d_resp_data_ok,
  output logic [63:0] d_resp_data,
  output logic        m_req_valid,
  output logic        m_req_write,
  output logic [2:0]  m_req_size,
  output logic [63:0] m_req_addr,
  output logic [7:0]  m_req_strobe,
  output logic [63:0] m_req_wdata,
  input  logic        m_resp_addr_ok,
  input  logic        m_resp_data_ok,
  input  logic [63:0] m_resp_data,
  output logic        grant_is_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic       addr_done_q, addr_done_d;
  logic [3:0] starve_q, starve_d;
  logic       i_hi_q, i_hi_d;
  logic       busy_i, busy_d;

  assign busy_i = (state_q == BUSY_I);
  assign busy_d = (state_q == BUSY_D);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_done_q <= 1'b0;
      starve_q    <= 4'd0;
      i_hi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_done_q <= addr_done_d;
      starve_q    <= starve_d;
      i_hi_q      <= i_hi_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_done_d = addr_done_q;
    starve_d    = starve_q;
    i_hi_d      = i_hi_q;
    case (state_q)
      IDLE: begin
        addr_done_d = 1'b0;
        if (d_req_valid && !(i_req_valid && starve_q == LIMIT)) begin
          state_d = BUSY_D;
          if (!i_req_valid) begin
            starve_d = 4'd0;
          end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (i_req_valid) begin
          state_d  = BUSY_I;
          starve_d = 4'd0;
          // Word select is latched so a requester dropping valid cannot corrupt it.
          i_hi_d   = i_req_addr[2];
        end else begin
          starve_d = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_resp_data_ok) begin
          state_d     = IDLE;
          addr_done_d = 1'b0;
        end else if (m_resp_addr_ok) begin
          addr_done_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        addr_done_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    m_req_valid    = (busy_i || busy_d) && !addr_done_q;
    m_req_write    = 1'b0;
    m_req_size     = 3'd0;
    m_req_addr     = 64'd0;
    m_req_strobe   = 8'd0;
    m_req_wdata    = 64'd0;
    i_resp_addr_ok = busy_i && m_resp_addr_ok;
    i_resp_data_ok = busy_i && m_resp_data_ok;
    i_resp_data    = 32'd0;
    d_resp_addr_ok = busy_d && m_resp_addr_ok;
    d_resp_data_ok = busy_d && m_resp_data_ok;
    d_resp_data    = 64'd0;
    grant_is_data  = busy_d;
    if (busy_i) begin
      m_req_size = 3'd2;
      m_req_addr = i_req_addr;
      if (m_resp_data_ok) begin
        i_resp_data = i_hi_q ? m_resp_data[63:32] : m_resp_data[31:0];
      end
    end
    if (busy_d) begin
      m_req_write  = d_req_write;
      m_req_size   = d_req_size;
      m_req_addr   = d_req_addr;
      m_req_strobe = d_req_strobe;
      m_req_wdata  = d_req_wdata;
      if (m_resp_data_ok) begin
        d_resp_data = m_resp_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration and routing rules.
module tb_mem_bus_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic [63:0] i_req_addr;
  logic        i_resp_addr_ok, i_resp_data_ok;
  logic [31:0] i_resp_data;
  logic        d_req_valid, d_req_write;
  logic [2:0]  d_req_size;
  logic [63:0] d_req_addr, d_req_wdata;
  logic [7:0]  d_req_strobe;
  logic        d_resp_addr_ok, d_resp_data_ok;
  logic [63:0] d_resp_data;
  logic        m_req_valid, m_req_write;
  logic [2:0]  m_req_size;
  logic [63:0] m_req_addr, m_req_wdata;
  logic [7:0]  m_req_strobe;
  logic        m_resp_addr_ok, m_resp_data_ok;
  logic [63:0] m_resp_data;
  logic        grant_is_data;

  int checks = 0;
  int failures = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr),
    .i_resp_addr_ok(i_resp_addr_ok), .i_resp_data_ok(i_resp_data_ok), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_size(d_req_size),
    .d_req_addr(d_req_addr), .d_req_strobe(d_req_strobe), .d_req_wdata(d_req_wdata),
    .d_resp_addr_ok(d_resp_addr_ok), .d_resp_data_ok(d_resp_data_ok), .d_resp_data(d_resp_data),
    .m_req_valid(m_req_valid), .m_req_write(m_req_write), .m_req_size(m_req_size),
    .m_req_addr(m_req_addr), .m_req_strobe(m_req_strobe), .m_req_wdata(m_req_wdata),
    .m_resp_addr_ok(m_resp_addr_ok), .m_resp_data_ok(m_resp_data_ok), .m_resp_data(m_resp_data),
    .grant_is_data(grant_is_data)
  );

  always #5 clk = ~clk;

  function automatic logic [241:0] all_outs();
    return {i_resp_addr_ok, i_resp_data_ok, i_resp_data, d_resp_addr_ok, d_resp_data_ok,
            d_resp_data, m_req_valid, m_req_write, m_req_size, m_req_addr, m_req_strobe,
            m_req_wdata, grant_is_data};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_req_valid = 0; i_req_addr = 0;
    d_req_valid = 0; d_req_write = 0; d_req_size = 0; d_req_addr = 0;
    d_req_strobe = 0; d_req_wdata = 0;
    m_resp_addr_ok = 0; m_resp_data_ok = 0; m_resp_data = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    d_req_valid = 1; i_req_valid = 1; m_resp_data_ok = 1; m_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc(); cyc();
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++; $display("FAIL reset_hold: outputs=%h required 0", all_outs());
    end
    clear_inputs();
    cyc();
    rst = 0;
    #1;
    checks++;
    if (all_outs() !== '0) begin
      failures++; $display("FAIL reset_release: outputs=%h required 0", all_outs());
    end
  endtask

  task automatic test_single_fetch();
    cyc(); i_req_valid = 1; i_req_addr = 64'h8000_0004; #1;
    checks++;
    if (m_req_valid !== 1'b0) begin failures++; $display("FAIL fetch_c0_valid: got %b required 0", m_req_valid); end
    cyc(); #1;
    checks++;
    if ({m_req_valid, m_req_write, m_req_size, m_req_addr, m_req_strobe, m_req_wdata, grant_is_data}
        !== {1'b1, 1'b0, 3'd2, 64'h8000_0004, 8'h00, 64'h0, 1'b0}) begin
      failures++; $display("FAIL fetch_c1_req: valid=%b wr=%b size=%0d addr=%h grant_d=%b",
                           m_req_valid, m_req_write, m_req_size, m_req_addr, grant_is_data);
    end
    cyc(); m_resp_addr_ok = 1; #1;
    checks++;
    if ({m_req_valid, i_resp_addr_ok, d_resp_addr_ok} !== 3'b110) begin
      failures++; $display("FAIL fetch_c2_addr_ok: got %b required 110", {m_req_valid, i_resp_addr_ok, d_resp_addr_ok});
    end
    cyc(); m_resp_addr_ok = 0; #1;
    checks++;
    if ({m_req_valid, i_resp_addr_ok} !== 2'b00) begin
      failures++; $display("FAIL fetch_c3_wait: got %b required 00", {m_req_valid, i_resp_addr_ok});
    end
    cyc(); m_resp_data_ok = 1; m_resp_data = 64'h1111_2222_3333_4444; #1;
    checks++;
    if ({i_resp_data_ok, i_resp_data, d_resp_data_ok, d_resp_data} !== {1'b1, 32'h1111_2222, 1'b0, 64'h0}) begin
      failures++; $display("FAIL fetch_c4_data: ok=%b data=%h d_ok=%b d_data=%h",
                           i_resp_data_ok, i_resp_data, d_resp_data_ok, d_resp_data);
    end
    cyc(); m_resp_data_ok = 0; i_req_valid = 0; #1;
    checks++;
    if ({m_req_valid, i_resp_data_ok, grant_is_data} !== 3'b000) begin
      failures++; $display("FAIL fetch_c5_idle: got %b required 000", {m_req_valid, i_resp_data_ok, grant_is_data});
    end
    cyc(); #1;
    checks++;
    if (m_req_valid !== 1'b0) begin failures++; $display("FAIL fetch_c6_idle: got %b required 0", m_req_valid); end
  endtask

  task automatic test_single_store();
    cyc();
    d_req_valid = 1; d_req_write = 1; d_req_size = 3; d_req_strobe = 8'hFF;
    d_req_wdata = 64'hDEAD_BEEF_0000_0001; d_req_addr = 64'h100;
    cyc(); #1;
    checks++;
    if ({m_req_valid, m_req_write, m_req_size, m_req_addr, m_req_strobe, m_req_wdata, grant_is_data}
        !== {1'b1, 1'b1, 3'd3, 64'h100, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1'b1}) begin
      failures++; $display("FAIL store_req: valid=%b wr=%b size=%0d addr=%h strb=%h wdata=%h grant_d=%b",
                           m_req_valid, m_req_write, m_req_size, m_req_addr, m_req_strobe, m_req_wdata, grant_is_data);
    end
    m_resp_addr_ok = 1; m_resp_data_ok = 1; m_resp_data = 64'h0123_4567_89AB_CDEF; #1;
    checks++;
    if ({d_resp_addr_ok, d_resp_data_ok, d_resp_data} !== {2'b11, 64'h0123_4567_89AB_CDEF}) begin
      failures++; $display("FAIL store_resp: a=%b d=%b data=%h required 1 1 0123456789abcdef",
                           d_resp_addr_ok, d_resp_data_ok, d_resp_data);
    end
    checks++;
    if ({i_resp_addr_ok, i_resp_data_ok, i_resp_data} !== 34'd0) begin
      failures++; $display("FAIL store_i_quiet: got %b %b %h required 0", i_resp_addr_ok, i_resp_data_ok, i_resp_data);
    end
    cyc(); clear_inputs(); #1;
    checks++;
    if ({m_req_valid, grant_is_data, d_resp_data_ok} !== 3'b000) begin
      failures++; $display("FAIL store_idle: got %b required 000", {m_req_valid, grant_is_data, d_resp_data_ok});
    end
  endtask

  task automatic test_contention();
    logic got[10];
    int   n = 0;
    int   last_cyc = 0;
    int   cnt = 0;
    logic exp_d;
    cyc();
    i_req_valid = 1; i_req_addr = 64'h4000_0000;
    d_req_valid = 1; d_req_addr = 64'h200; d_req_size = 3;
    for (int c = 1; c <= 100 && n < 10; c++) begin
      cyc();
      m_resp_addr_ok = 0; m_resp_data_ok = 0;
      #1;
      if (m_req_valid === 1'b1) begin
        got[n] = grant_is_data;
        m_resp_addr_ok = 1; m_resp_data_ok = 1; m_resp_data = {$urandom, $urandom};
        #1;
        checks++;
        if ({d_resp_data_ok, i_resp_data_ok} !== {grant_is_data, ~grant_is_data}) begin
          failures++; $display("FAIL contention_route[%0d]: d_ok=%b i_ok=%b grant_d=%b",
                               n, d_resp_data_ok, i_resp_data_ok, grant_is_data);
        end
        n++;
        last_cyc = c;
      end
    end
    cyc(); clear_inputs();
    cyc();
    checks++;
    if (n != 10) begin
      failures++; $display("FAIL contention_timeout: grants=%0d required 10", n);
    end else begin
      for (int k = 0; k < 10; k++) begin
        if (cnt == LIMIT) begin exp_d = 0; cnt = 0; end
        else begin exp_d = 1; cnt = (cnt < 15) ? cnt + 1 : 15; end
        checks++;
        if (got[k] !== exp_d) begin
          failures++; $display("FAIL contention_order[%0d]: grant_d=%b required %b", k, got[k], exp_d);
        end
      end
      checks++;
      if (last_cyc != 19) begin
        failures++; $display("FAIL contention_throughput: last grant cycle=%0d required 19", last_cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(); d_req_valid = 1; d_req_size = 2; d_req_addr = 64'h200;
    cyc(); m_resp_addr_ok = 1; #1;
    checks++;
    if (d_resp_addr_ok !== 1'b1) begin failures++; $display("FAIL rmid_addr_ok: got %b required 1", d_resp_addr_ok); end
    cyc(); m_resp_addr_ok = 0; #1;
    checks++;
    if ({m_req_valid, grant_is_data} !== 2'b01) begin
      failures++; $display("FAIL rmid_addr_done: got %b required 01", {m_req_valid, grant_is_data});
    end
    rst = 1;
    cyc(); rst = 0; #1;
    checks++;
    if (all_outs() !== '0) begin failures++; $display("FAIL rmid_outputs: got %h required 0", all_outs()); end
    cyc(); #1;
    checks++;
    if ({m_req_valid, grant_is_data, m_req_addr} !== {2'b11, 64'h200}) begin
      failures++; $display("FAIL rmid_regrant: valid=%b grant_d=%b addr=%h", m_req_valid, grant_is_data, m_req_addr);
    end
    m_resp_addr_ok = 1; m_resp_data_ok = 1; m_resp_data = 64'h77; #1;
    checks++;
    if ({d_resp_data_ok, d_resp_data} !== {1'b1, 64'h77}) begin
      failures++; $display("FAIL rmid_complete: ok=%b data=%h", d_resp_data_ok, d_resp_data);
    end
    cyc(); clear_inputs();
  endtask

  task automatic test_stray();
    cyc(); m_resp_data_ok = 1; m_resp_addr_ok = 1; m_resp_data = {$urandom, $urandom}; #1;
    checks++;
    if ({i_resp_addr_ok, i_resp_data_ok, i_resp_data, d_resp_addr_ok, d_resp_data_ok, d_resp_data,
         m_req_valid, grant_is_data} !== '0) begin
      failures++; $display("FAIL stray_ignored: i=%b%b d=%b%b mvalid=%b", i_resp_addr_ok, i_resp_data_ok,
                           d_resp_addr_ok, d_resp_data_ok, m_req_valid);
    end
    cyc(); clear_inputs(); #1;
    checks++;
    if ({m_req_valid, grant_is_data} !== 2'b00) begin
      failures++; $display("FAIL stray_state: got %b required 00", {m_req_valid, grant_is_data});
    end
    i_req_valid = 1; i_req_addr = 64'h8000_0000;
    cyc(); #1;
    m_resp_addr_ok = 1; m_resp_data_ok = 1; m_resp_data = 64'hAAAA_BBBB_CCCC_DDDD; #1;
    checks++;
    if ({i_resp_data_ok, i_resp_data} !== {1'b1, 32'hCCCC_DDDD}) begin
      failures++; $display("FAIL stray_fetch: ok=%b data=%h required 1 ccccdddd", i_resp_data_ok, i_resp_data);
    end
    cyc(); clear_inputs();
  endtask

  task automatic test_requester_drop();
    int pulses = 0;
    cyc(); i_req_valid = 1; i_req_addr = 64'h1000;
    cyc(); m_resp_addr_ok = 1; #1;
    checks++;
    if (i_resp_addr_ok !== 1'b1) begin failures++; $display("FAIL drop_addr_ok: got %b required 1", i_resp_addr_ok); end
    cyc(); m_resp_addr_ok = 0; i_req_valid = 0; #1;
    checks++;
    if ({m_req_valid, i_resp_data_ok} !== 2'b00) begin
      failures++; $display("FAIL drop_wait: got %b required 00", {m_req_valid, i_resp_data_ok});
    end
    cyc(); m_resp_data_ok = 1; m_resp_data = 64'h5555_6666_7777_8888; #1;
    if (i_resp_data_ok === 1'b1) pulses++;
    checks++;
    if ({i_resp_data_ok, i_resp_data} !== {1'b1, 32'h7777_8888}) begin
      failures++; $display("FAIL drop_data: ok=%b data=%h required 1 77778888", i_resp_data_ok, i_resp_data);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(); m_resp_data_ok = 0; #1;
      if (i_resp_data_ok === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || m_req_valid !== 1'b0) begin
      failures++; $display("FAIL drop_once: pulses=%0d mvalid=%b required 1 0", pulses, m_req_valid);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int         owner = 0;   // 0 none, 1 fetch, 2 data
    bit         mdone = 0;
    int         cnt = 0;
    bit         i_fin = 0, d_fin = 0;
    bit         ihi = 0;
    logic [31:0] exp_idat;
    logic [63:0] exp_ddat;
    logic [142:0] exp_req;
    cyc(); clear_inputs();
    cyc();
    for (int c = 0; c < 1500; c++) begin
      cyc();
      if (i_fin || (!i_req_valid && $urandom_range(2, 0) == 0)) begin
        i_req_valid = i_fin ? $urandom_range(1, 0) : 1'b1;
        i_req_addr  = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
        i_fin = 0;
      end
      if (d_fin || (!d_req_valid && $urandom_range(2, 0) == 0)) begin
        d_req_valid  = d_fin ? $urandom_range(1, 0) : 1'b1;
        d_req_write  = $urandom_range(1, 0);
        d_req_size   = $urandom_range(3, 0);
        d_req_addr   = {$urandom, $urandom};
        d_req_strobe = $urandom_range(255, 0);
        d_req_wdata  = {$urandom, $urandom};
        d_fin = 0;
      end
      m_resp_addr_ok = 0; m_resp_data_ok = 0; m_resp_data = {$urandom, $urandom};
      if (owner == 0) begin
        if ($urandom_range(7, 0) == 0) begin m_resp_data_ok = 1; m_resp_addr_ok = $urandom_range(1, 0); end
      end else if (!mdone) begin
        case ($urandom_range(7, 0))
          0: begin m_resp_addr_ok = 1; m_resp_data_ok = 1; end
          1, 2: m_resp_addr_ok = 1;
          3: m_resp_data_ok = 1;
          default: ;
        endcase
      end else begin
        m_resp_data_ok = ($urandom_range(2, 0) == 0);
      end
      #1;
      checks++;
      if ({m_req_valid, grant_is_data} !== {owner != 0 && !mdone, owner == 2}) begin
        failures++; $display("FAIL rand_state[%0d]: mvalid=%b grant_d=%b owner=%0d done=%b",
                             c, m_req_valid, grant_is_data, owner, mdone);
      end
      if (owner != 0 && !mdone) begin
        exp_req = (owner == 1) ? {1'b0, 3'd2, i_req_addr, 8'h00, 64'h0}
                               : {d_req_write, d_req_size, d_req_addr, d_req_strobe, d_req_wdata};
        checks++;
        if ({m_req_write, m_req_size, m_req_addr, m_req_strobe, m_req_wdata} !== exp_req) begin
          failures++; $display("FAIL rand_fields[%0d]: wr=%b size=%0d addr=%h owner=%0d",
                               c, m_req_write, m_req_size, m_req_addr, owner);
        end
      end
      exp_idat = 0; exp_ddat = 0;
      if (owner == 1 && m_resp_data_ok) exp_idat = ihi ? m_resp_data[63:32] : m_resp_data[31:0];
      if (owner == 2 && m_resp_data_ok) exp_ddat = m_resp_data;
      checks++;
      if ({i_resp_addr_ok, i_resp_data_ok, i_resp_data} !==
          {owner == 1 && m_resp_addr_ok, owner == 1 && m_resp_data_ok, exp_idat}) begin
        failures++; $display("FAIL rand_iresp[%0d]: a=%b d=%b data=%h required data %h",
                             c, i_resp_addr_ok, i_resp_data_ok, i_resp_data, exp_idat);
      end
      checks++;
      if ({d_resp_addr_ok, d_resp_data_ok, d_resp_data} !==
          {owner == 2 && m_resp_addr_ok, owner == 2 && m_resp_data_ok, exp_ddat}) begin
        failures++; $display("FAIL rand_dresp[%0d]: a=%b d=%b data=%h required data %h",
                             c, d_resp_addr_ok, d_resp_data_ok, d_resp_data, exp_ddat);
      end
      if (owner != 0) begin
        if (m_resp_data_ok) begin
          if (owner == 1) i_fin = 1; else d_fin = 1;
          owner = 0; mdone = 0;
        end else if (m_resp_addr_ok) begin
          mdone = 1;
        end
      end else if (d_req_valid && !(i_req_valid && cnt == LIMIT)) begin
        owner = 2;
        cnt = !i_req_valid ? 0 : (cnt < 15 ? cnt + 1 : 15);
      end else if (i_req_valid) begin
        owner = 1; cnt = 0; ihi = i_req_addr[2];
      end else begin
        cnt = 0;
      end
    end
    cyc(); clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_single_fetch();
    test_single_store();
    test_contention();
    test_reset_mid();
    test_stray();
    test_requester_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one memory request port between the instruction-fetch requester (the program counter's ibus) and the data requester (the load/store dbus). It grants one transaction at a time, forwards the request downstream, and steers the response back to the granted requester. Data has priority, bounded by a starvation counter so fetch always progresses. Sits between the core pipeline and the single memory/cache bus.

Parameters:
STARVE_LIMIT, 4, max consecutive dbus grants while an ibus request is pending before ibus is forced. Range 1..15.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req_valid  in  1  fetch request, held until i_resp_data_ok
i_req_addr  in  64  fetch byte address, 4-byte aligned
i_resp_addr_ok  out  1  pulse: fetch address accepted downstream
i_resp_data_ok  out  1  pulse: fetch data valid
i_resp_data  out  32  instruction word
d_req_valid  in  1  data request, held until d_resp_data_ok
d_req_write  in  1  1 = store
d_req_size  in  3  log2 bytes (0..3)
d_req_addr  in  64  data byte address
d_req_strobe  in  8  byte write enables
d_req_wdata  in  64  store data
d_resp_addr_ok  out  1  pulse: data address accepted
d_resp_data_ok  out  1  pulse: data valid / store done
d_resp_data  out  64  load data
m_req_valid  out  1  downstream request
m_req_write  out  1  downstream write flag
m_req_size  out  3  downstream size
m_req_addr  out  64  downstream address
m_req_strobe  out  8  downstream strobes
m_req_wdata  out  64  downstream store data
m_resp_addr_ok  in  1  downstream address accepted
m_resp_data_ok  in  1  downstream data / completion
m_resp_data  in  64  downstream read data
grant_is_data  out  1  debug: current grant is dbus

Behaviour:
- States: IDLE, BUSY_I, BUSY_D. A flag addr_done marks that the address phase is complete.
- Reset (sync): state IDLE, addr_done 0, starve counter 0. All outputs 0. Any in-flight downstream transaction is abandoned; downstream is reset by the same rst.
- IDLE arbitration on a registered decision, so the grant takes effect next cycle:
  - Only d valid -> BUSY_D.
  - Only i valid -> BUSY_I.
  - Both valid: BUSY_I if starve counter == STARVE_LIMIT, else BUSY_D.
  - Neither valid -> stay IDLE.
- Starve counter, 4 bits, saturating:
  - Increments when BUSY_D is entered while i_req_valid = 1.
  - Clears when BUSY_I is entered or i_req_valid = 0 in IDLE.
- BUSY_x, request phase:
  - m_req_valid = 1 while addr_done = 0. Fields are muxed combinationally from the granted requester.
  - For ibus: write = 0, size = 2, strobe = 0, wdata = 0, addr = i_req_addr.
  - m_req_valid is 0 while addr_done = 1.
- m_resp_addr_ok in BUSY_x:
  - Sets addr_done.
  - Pulses x_resp_addr_ok the same cycle (combinational pass-through).
- m_resp_data_ok in BUSY_x, combinational same-cycle forwarding:
  - Pulses x_resp_data_ok.
  - BUSY_D: d_resp_data = m_resp_data.
  - BUSY_I: i_resp_data = m_resp_addr[2] ? m_resp_data[63:32] : m_resp_data[31:0], selected on the granted address.
  - Next state IDLE, addr_done cleared.
  - Minimum turnaround is one IDLE cycle between transactions.
- addr_ok and data_ok may arrive in the same cycle. Both pulses are forwarded and the transaction completes.
- data_ok without a prior or simultaneous addr_ok is treated as completion. addr_done is irrelevant in that case.
- Response pulses never go to the non-granted requester. Its resp outputs stay 0 and its data outputs are 0.
- m_resp_* received in IDLE is ignored.
- A requester dropping valid mid-transaction does not abort: the transaction completes downstream and the pulse is still emitted.
- grant_is_data = (state == BUSY_D).
- Zero throughput loss beyond the one IDLE cycle. No queuing, single outstanding transaction.

Test Plan:
- Single fetch: i_req_valid = 1, addr 0x8000_0004. Memory gives addr_ok at cycle 2 and data_ok at cycle 4 with data 0x1111_2222_3333_4444 -> m_req_valid in cycles 1–2 only, i_resp_data_ok at cycle 4, i_resp_data = 0x1111_2222, back to IDLE at cycle 5.
- Single store: d write, size 3, strobe 0xFF, wdata 0xDEAD_BEEF_0000_0001, addr 0x100. addr_ok and data_ok arrive in the same cycle -> m_req fields match exactly, d_resp_addr_ok and d_resp_data_ok pulse together, i_resp outputs stay 0.
- Contention with STARVE_LIMIT = 4: both valid continuously, fixed 1-cycle memory -> grant order D,D,D,D,I,D,D,D,D,I. Starve counter resets after each I grant.
- Reset mid-transaction: assert rst while BUSY_D with addr_done = 1 -> next cycle state IDLE and all outputs 0. A subsequent d request is granted normally.
- Stray response: m_resp_data_ok pulses in IDLE -> no requester pulse, state unchanged. Fetch at 0x8000_0000 with data 0xAAAA_BBBB_CCCC_DDDD returns 0xCCCC_DDDD.
- Requester drop: i_req_valid deasserted after addr_ok -> transaction finishes, i_resp_data_ok still pulses once, returns to IDLE.
